mips_pipe_core: RTL and testbench

- Single-clock, 5-stage (IF/ID/EX/MEM/WB) 32-bit MIPS-subset integer pipeline. Next generation of the team's two-phase pipeline.
- Adds a parametrised datapath width and PC width, an async reset, and full hazard handling: forwarding or interlock mode, load-use stall, and branch flush.
- Instruction and data memories sit outside the block on simple single-cycle ports. The block is the compute core of the processor top level.

---
 rtl/mips_pipe_pkg.sv | 67 ++++++
 rtl/mips_pipe_core_if.sv | 22 ++
 rtl/mips_hazard_unit.sv | 58 +++++
 rtl/mips_pipe_core.sv | 229 ++++++++++++++++++++++
 tb/tb_mips_pipe_core.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/mips_pipe_pkg.sv
// Shared opcodes, instruction classes and instruction-field helpers for the 5-stage MIPS-subset core.
package mips_pipe_pkg;

  localparam logic [5:0] OP_ADD   = 6'b000000;
  localparam logic [5:0] OP_SUB   = 6'b000001;
  localparam logic [5:0] OP_AND   = 6'b000010;
  localparam logic [5:0] OP_OR    = 6'b000011;
  localparam logic [5:0] OP_SLT   = 6'b000100;
  localparam logic [5:0] OP_MUL   = 6'b000101;
  localparam logic [5:0] OP_LW    = 6'b001000;
  localparam logic [5:0] OP_SW    = 6'b001001;
  localparam logic [5:0] OP_ADDI  = 6'b001010;
  localparam logic [5:0] OP_SUBI  = 6'b001011;
  localparam logic [5:0] OP_SLTI  = 6'b001100;
  localparam logic [5:0] OP_BNEQZ = 6'b001101;
  localparam logic [5:0] OP_BEQZ  = 6'b001110;
  localparam logic [5:0] OP_HLT   = 6'b111111;

  typedef enum logic [2:0] {RR_ALU, RM_ALU, LOAD, STORE, BRANCH, HALT, NOP} cls_e;
  typedef enum logic [1:0] {FWD_NONE, FWD_MEM, FWD_WB} fwd_e;

  function automatic logic [5:0] f_op(input logic [31:0] ins);
    return ins[31:26];
  endfunction

  function automatic logic [4:0] f_rs(input logic [31:0] ins);
    return ins[25:21];
  endfunction

  function automatic logic [4:0] f_rt(input logic [31:0] ins);
    return ins[20:16];
  endfunction

  function automatic logic [4:0] f_rd(input logic [31:0] ins);
    return ins[15:11];
  endfunction

  function automatic logic [15:0] f_imm(input logic [31:0] ins);
    return ins[15:0];
  endfunction

  // Undefined opcodes fall into NOP; the core flags them as illegal when they retire.
  function automatic cls_e decode_cls(input logic [5:0] op);
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_MUL: return RR_ALU;
      OP_ADDI, OP_SUBI, OP_SLTI:                     return RM_ALU;
      OP_LW:                                         return LOAD;
      OP_SW:                                         return STORE;
      OP_BNEQZ, OP_BEQZ:                             return BRANCH;
      OP_HLT:                                        return HALT;
      default:                                       return NOP;
    endcase
  endfunction

  function automatic logic uses_rs(input cls_e c);
    return (c == RR_ALU) || (c == RM_ALU) || (c == LOAD) || (c == STORE) || (c == BRANCH);
  endfunction

  function automatic logic uses_rt(input cls_e c);
    return (c == RR_ALU) || (c == STORE);
  endfunction

  function automatic logic writes_reg(input cls_e c);
    return (c == RR_ALU) || (c == RM_ALU) || (c == LOAD);
  endfunction

endpackage

// File: rtl/mips_pipe_core_if.sv
// Instruction/data memory port bundle; master side is the core, slave side the memories.
interface mips_pipe_core_if #(
  parameter int XLEN = 32,
  parameter int PC_W = 10
);
  logic [PC_W-1:0] imem_addr;
  logic [31:0]     imem_rdata;
  logic [PC_W-1:0] dmem_addr;
  logic [XLEN-1:0] dmem_wdata;
  logic            dmem_we;
  logic [XLEN-1:0] dmem_rdata;

  modport master (
    output imem_addr, dmem_addr, dmem_wdata, dmem_we,
    input  imem_rdata, dmem_rdata
  );

  modport slave (
    input  imem_addr, dmem_addr, dmem_wdata, dmem_we,
    output imem_rdata, dmem_rdata
  );
endinterface

// File: rtl/mips_hazard_unit.sv
// Combinational hazard logic: load-use / RAW interlock, taken-branch flush and EX operand forwarding select.
// Zero latency; a taken branch in EX always wins over a stall request from ID.
module mips_hazard_unit import mips_pipe_pkg::*; #(
  parameter int FWD_EN = 1
) (
  input  logic       id_vld,
  input  logic [4:0] id_rs,
  input  logic [4:0] id_rt,
  input  logic       id_use_rs,
  input  logic       id_use_rt,
  input  logic       ex_vld,
  input  cls_e       ex_cls,
  input  logic       ex_wr,
  input  logic [4:0] ex_dest,
  input  logic [4:0] ex_rs,
  input  logic [4:0] ex_rt,
  input  logic       ex_br_taken,
  input  logic       mem_vld,
  input  cls_e       mem_cls,
  input  logic       mem_wr,
  input  logic [4:0] mem_dest,
  input  logic       wb_vld,
  input  logic       wb_wr,
  input  logic [4:0] wb_dest,
  output logic       stall,
  output logic       flush,
  output fwd_e       fwd_a_sel,
  output fwd_e       fwd_b_sel
);

  logic ex_prod, mem_prod, wb_prod, ex_hit, mem_hit, load_use, raw_wait;

  assign ex_prod  = ex_vld && ex_wr && (ex_dest != 5'd0);
  assign mem_prod = mem_vld && mem_wr && (mem_dest != 5'd0);
  assign wb_prod  = wb_vld && wb_wr && (wb_dest != 5'd0);

  assign ex_hit  = ex_prod && ((id_use_rs && id_rs == ex_dest) || (id_use_rt && id_rt == ex_dest));
  assign mem_hit = mem_prod && ((id_use_rs && id_rs == mem_dest) || (id_use_rt && id_rt == mem_dest));

  assign load_use = ex_hit && (ex_cls == LOAD);
  assign raw_wait = (FWD_EN == 0) && (ex_hit || mem_hit);

  assign flush = ex_vld && (ex_cls == BRANCH) && ex_br_taken;
  assign stall = id_vld && (load_use || raw_wait) && !flush;

  // A load still in MEM has no data yet; the load-use bubble guarantees it is picked up from WB.
  always_comb begin
    fwd_a_sel = FWD_NONE;
    fwd_b_sel = FWD_NONE;
    if (FWD_EN != 0) begin
      if (mem_prod && mem_cls != LOAD && mem_dest == ex_rs) fwd_a_sel = FWD_MEM;
      else if (wb_prod && wb_dest == ex_rs)                 fwd_a_sel = FWD_WB;
      if (mem_prod && mem_cls != LOAD && mem_dest == ex_rt) fwd_b_sel = FWD_MEM;
      else if (wb_prod && wb_dest == ex_rt)                 fwd_b_sel = FWD_WB;
    end
  end

endmodule

// File: rtl/mips_pipe_core.sv
// 5-stage IF/ID/EX/MEM/WB MIPS-subset core with forwarding or interlock, load-use stall and branch flush.
// Results retire 4 edges after fetch; branches resolve in EX with a 2-slot penalty when taken.
module mips_pipe_core import mips_pipe_pkg::*; #(
  parameter int              XLEN     = 32,
  parameter int              PC_W     = 10,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int              FWD_EN   = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  mips_pipe_core_if.master mem,
  input  logic [4:0]       dbg_raddr,
  output logic [XLEN-1:0]  dbg_rdata,
  output logic             halted,
  output logic             err_illegal,
  output logic [31:0]      instret
);

  typedef struct packed {
    logic            vld;
    logic [PC_W-1:0] pc;
    logic [31:0]     ins;
  } if_id_t;

  typedef struct packed {
    logic            vld;
    logic [PC_W-1:0] pc;
    cls_e            cls;
    logic [5:0]      op;
    logic [4:0]      rs;
    logic [4:0]      rt;
    logic [4:0]      dest;
    logic            wr;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [15:0]     imm;
  } id_ex_t;

  typedef struct packed {
    logic            vld;
    cls_e            cls;
    logic [4:0]      dest;
    logic            wr;
    logic [XLEN-1:0] res;
    logic [XLEN-1:0] sdat;
  } ex_mem_t;

  typedef struct packed {
    logic            vld;
    cls_e            cls;
    logic [4:0]      dest;
    logic            wr;
    logic [XLEN-1:0] res;
  } mem_wb_t;

  logic [PC_W-1:0] pc_q;
  logic            fetch_stop_q;
  if_id_t          if_id_q;
  id_ex_t          id_ex_q, id_ex_d;
  ex_mem_t         ex_mem_q, ex_mem_d;
  mem_wb_t         mem_wb_q, mem_wb_d;
  logic [XLEN-1:0] rf [32];

  logic            stall, flush, fetch_stop, wb_we, br_taken;
  fwd_e            fwd_a_sel, fwd_b_sel;
  cls_e            id_cls;
  logic [4:0]      id_rs, id_rt, id_dest;
  logic [XLEN-1:0] id_a, id_b, a_fwd, b_fwd, imm_x, alu;
  logic [PC_W-1:0] br_target;

  // ---------------- ID ----------------
  assign id_cls  = decode_cls(f_op(if_id_q.ins));
  assign id_rs   = f_rs(if_id_q.ins);
  assign id_rt   = f_rt(if_id_q.ins);
  assign id_dest = (id_cls == RR_ALU) ? f_rd(if_id_q.ins) : id_rt;

  // Write-first register file: a retiring result is visible to the same-cycle ID read.
  assign wb_we = mem_wb_q.vld && mem_wb_q.wr;
  assign id_a  = (wb_we && mem_wb_q.dest == id_rs) ? mem_wb_q.res : rf[id_rs];
  assign id_b  = (wb_we && mem_wb_q.dest == id_rt) ? mem_wb_q.res : rf[id_rt];
  assign dbg_rdata = rf[dbg_raddr];

  assign fetch_stop = fetch_stop_q || (if_id_q.vld && id_cls == HALT && !flush);

  always_comb begin
    id_ex_d      = '0;
    id_ex_d.vld  = if_id_q.vld;
    id_ex_d.pc   = if_id_q.pc;
    id_ex_d.cls  = id_cls;
    id_ex_d.op   = f_op(if_id_q.ins);
    id_ex_d.rs   = id_rs;
    id_ex_d.rt   = id_rt;
    id_ex_d.dest = id_dest;
    id_ex_d.wr   = writes_reg(id_cls) && (id_dest != 5'd0);
    id_ex_d.a    = id_a;
    id_ex_d.b    = id_b;
    id_ex_d.imm  = f_imm(if_id_q.ins);
  end

  mips_hazard_unit #(.FWD_EN(FWD_EN)) u_hazard (
    .id_vld      (if_id_q.vld),
    .id_rs       (id_rs),
    .id_rt       (id_rt),
    .id_use_rs   (uses_rs(id_cls)),
    .id_use_rt   (uses_rt(id_cls)),
    .ex_vld      (id_ex_q.vld),
    .ex_cls      (id_ex_q.cls),
    .ex_wr       (id_ex_q.wr),
    .ex_dest     (id_ex_q.dest),
    .ex_rs       (id_ex_q.rs),
    .ex_rt       (id_ex_q.rt),
    .ex_br_taken (br_taken),
    .mem_vld     (ex_mem_q.vld),
    .mem_cls     (ex_mem_q.cls),
    .mem_wr      (ex_mem_q.wr),
    .mem_dest    (ex_mem_q.dest),
    .wb_vld      (mem_wb_q.vld),
    .wb_wr       (mem_wb_q.wr),
    .wb_dest     (mem_wb_q.dest),
    .stall       (stall),
    .flush       (flush),
    .fwd_a_sel   (fwd_a_sel),
    .fwd_b_sel   (fwd_b_sel)
  );

  // ---------------- EX ----------------
  always_comb begin
    case (fwd_a_sel)
      FWD_MEM: a_fwd = ex_mem_q.res;
      FWD_WB:  a_fwd = mem_wb_q.res;
      default: a_fwd = id_ex_q.a;
    endcase
    case (fwd_b_sel)
      FWD_MEM: b_fwd = ex_mem_q.res;
      FWD_WB:  b_fwd = mem_wb_q.res;
      default: b_fwd = id_ex_q.b;
    endcase
  end

  assign imm_x     = XLEN'($signed(id_ex_q.imm));
  assign br_taken  = (id_ex_q.op == OP_BEQZ) ? (a_fwd == '0) : (a_fwd != '0);
  assign br_target = id_ex_q.pc + PC_W'(1) + PC_W'($signed(id_ex_q.imm));

  always_comb begin
    case (id_ex_q.op)
      OP_ADD:                 alu = a_fwd + b_fwd;
      OP_SUB:                 alu = a_fwd - b_fwd;
      OP_AND:                 alu = a_fwd & b_fwd;
      OP_OR:                  alu = a_fwd | b_fwd;
      OP_SLT:                 alu = XLEN'($signed(a_fwd) < $signed(b_fwd));
      OP_MUL:                 alu = a_fwd * b_fwd;
      OP_ADDI, OP_LW, OP_SW:  alu = a_fwd + imm_x;
      OP_SUBI:                alu = a_fwd - imm_x;
      OP_SLTI:                alu = XLEN'($signed(a_fwd) < $signed(imm_x));
      default:                alu = '0;
    endcase
  end

  always_comb begin
    ex_mem_d      = '0;
    ex_mem_d.vld  = id_ex_q.vld;
    ex_mem_d.cls  = id_ex_q.cls;
    ex_mem_d.dest = id_ex_q.dest;
    ex_mem_d.wr   = id_ex_q.wr;
    ex_mem_d.res  = alu;
    ex_mem_d.sdat = b_fwd;
  end

  // ---------------- MEM ----------------
  assign mem.imem_addr  = pc_q;
  assign mem.dmem_addr  = ex_mem_q.res[PC_W-1:0];
  assign mem.dmem_wdata = ex_mem_q.sdat;
  assign mem.dmem_we    = ex_mem_q.vld && (ex_mem_q.cls == STORE) && !halted;

  always_comb begin
    mem_wb_d      = '0;
    mem_wb_d.vld  = ex_mem_q.vld;
    mem_wb_d.cls  = ex_mem_q.cls;
    mem_wb_d.dest = ex_mem_q.dest;
    mem_wb_d.wr   = ex_mem_q.wr;
    mem_wb_d.res  = (ex_mem_q.cls == LOAD) ? mem.dmem_rdata : ex_mem_q.res;
  end

  // ---------------- state ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q         <= RESET_PC;
      fetch_stop_q <= 1'b0;
      if_id_q      <= '0;
      id_ex_q      <= '0;
      ex_mem_q     <= '0;
      mem_wb_q     <= '0;
      halted       <= 1'b0;
      err_illegal  <= 1'b0;
      instret      <= '0;
    end else if (!halted) begin
      if (flush)                     pc_q <= br_target;
      else if (!stall && !fetch_stop) pc_q <= pc_q + PC_W'(1);
      fetch_stop_q <= fetch_stop;

      if (flush || (!stall && fetch_stop)) begin
        if_id_q <= '0;
      end else if (!stall) begin
        if_id_q.vld <= 1'b1;
        if_id_q.pc  <= pc_q;
        if_id_q.ins <= mem.imem_rdata;
      end

      id_ex_q  <= (flush || stall) ? '0 : id_ex_d;
      ex_mem_q <= ex_mem_d;
      mem_wb_q <= mem_wb_d;

      if (mem_wb_q.vld) begin
        instret <= instret + 32'd1;
        if (mem_wb_q.cls == HALT) halted      <= 1'b1;
        if (mem_wb_q.cls == NOP)  err_illegal <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 32; i++) rf[i] <= '0;
    end else if (!halted && wb_we) begin
      rf[mem_wb_q.dest] <= mem_wb_q.res;
    end
  end

endmodule

// File: tb/tb_mips_pipe_core.sv
// Directed programs run side by side on a forwarding core and an interlocked core.
module tb_mips_pipe_core;

  localparam logic [31:0] HLT = 32'hFC00_0000;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [4:0] dbg_raddr = 5'd0;
  always #5 clk = ~clk;

  mips_pipe_core_if #(.XLEN(32), .PC_W(10)) bus_f ();
  mips_pipe_core_if #(.XLEN(32), .PC_W(10)) bus_n ();

  logic [31:0] dbg_f, dbg_n, iret_f, iret_n;
  logic        halted_f, halted_n, ill_f, ill_n;

  mips_pipe_core #(.XLEN(32), .PC_W(10), .RESET_PC(10'd0), .FWD_EN(1)) u_fwd (
    .clk(clk), .rst_n(rst_n), .mem(bus_f), .dbg_raddr(dbg_raddr), .dbg_rdata(dbg_f),
    .halted(halted_f), .err_illegal(ill_f), .instret(iret_f));

  mips_pipe_core #(.XLEN(32), .PC_W(10), .RESET_PC(10'd0), .FWD_EN(0)) u_nofwd (
    .clk(clk), .rst_n(rst_n), .mem(bus_n), .dbg_raddr(dbg_raddr), .dbg_rdata(dbg_n),
    .halted(halted_n), .err_illegal(ill_n), .instret(iret_n));

  logic [31:0] imem [1024];
  logic [31:0] dmem_f [1024];
  logic [31:0] dmem_n [1024];
  int          we_cnt_f, we_cnt_n, we_addr_f, we_dat_f;
  int          tests, fails;

  assign bus_f.imem_rdata = imem[bus_f.imem_addr];
  assign bus_n.imem_rdata = imem[bus_n.imem_addr];
  assign bus_f.dmem_rdata = dmem_f[bus_f.dmem_addr];
  assign bus_n.dmem_rdata = dmem_n[bus_n.dmem_addr];

  // Stores land mid-cycle, well clear of the edge where a load would sample.
  always @(negedge clk) begin
    if (bus_f.dmem_we) begin
      dmem_f[bus_f.dmem_addr] = bus_f.dmem_wdata;
      we_cnt_f  = we_cnt_f + 1;
      we_addr_f = int'(bus_f.dmem_addr);
      we_dat_f  = int'(bus_f.dmem_wdata);
    end
    if (bus_n.dmem_we) begin
      dmem_n[bus_n.dmem_addr] = bus_n.dmem_wdata;
      we_cnt_n = we_cnt_n + 1;
    end
  end

  function automatic logic [31:0] rr(input logic [5:0] op, input int rs, input int rt, input int rd);
    return {op, 5'(rs), 5'(rt), 5'(rd), 11'd0};
  endfunction

  function automatic logic [31:0] ri(input logic [5:0] op, input int rs, input int rt, input int imm);
    return {op, 5'(rs), 5'(rt), 16'(imm)};
  endfunction

  task automatic prep(input logic [31:0] p0, p1, p2, p3, p4, input int ma, input logic [31:0] mv);
    rst_n = 1'b0;
    #1;
    for (int i = 0; i < 1024; i++) begin
      imem[i] = HLT; dmem_f[i] = '0; dmem_n[i] = '0;
    end
    imem[0] = p0; imem[1] = p1; imem[2] = p2; imem[3] = p3; imem[4] = p4;
    dmem_f[ma] = mv; dmem_n[ma] = mv;
    we_cnt_f = 0; we_cnt_n = 0; we_addr_f = -1; we_dat_f = -1;
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Returns the edge number (counted from reset release) on which halted rose; 0 means it never did.
  task automatic run_to_halt(output int hf, output int hn);
    hf = 0; hn = 0;
    for (int n = 1; n <= 200; n++) begin
      @(posedge clk);
      #1;
      if (halted_f && hf == 0) hf = n;
      if (halted_n && hn == 0) hn = n;
      if (hf != 0 && hn != 0) break;
    end
  endtask

  task automatic get_reg(input int r, output logic [31:0] vf, output logic [31:0] vn);
    dbg_raddr = 5'(r);
    #1;
    vf = dbg_f;
    vn = dbg_n;
  endtask

  task automatic test_reset;
    int nz_f, nz_n;
    logic [31:0] vf, vn;
    prep(ri(6'b001010, 0, 1, 10), ri(6'b001010, 0, 2, 20), rr(6'b000000, 1, 2, 3), HLT, HLT, 0, 32'd0);
    repeat (6) @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    tests++; if (bus_f.imem_addr !== 10'd0 || bus_n.imem_addr !== 10'd0) begin fails++; $display("FAIL reset imem_addr: got %0d/%0d want 0", bus_f.imem_addr, bus_n.imem_addr); end
    tests++; if (bus_f.dmem_we !== 1'b0 || bus_n.dmem_we !== 1'b0) begin fails++; $display("FAIL reset dmem_we: got %b/%b want 0", bus_f.dmem_we, bus_n.dmem_we); end
    tests++; if (halted_f !== 1'b0 || halted_n !== 1'b0 || ill_f !== 1'b0 || ill_n !== 1'b0) begin fails++; $display("FAIL reset flags: halted %b/%b illegal %b/%b want 0", halted_f, halted_n, ill_f, ill_n); end
    tests++; if (iret_f !== 32'd0 || iret_n !== 32'd0) begin fails++; $display("FAIL reset instret: got %0d/%0d want 0", iret_f, iret_n); end
    nz_f = 0; nz_n = 0;
    for (int r = 0; r < 32; r++) begin
      get_reg(r, vf, vn);
      if (vf !== 32'd0) nz_f++;
      if (vn !== 32'd0) nz_n++;
    end
    tests++; if (nz_f != 0 || nz_n != 0) begin fails++; $display("FAIL reset regfile: nonzero regs %0d/%0d want 0", nz_f, nz_n); end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    tests++; if (bus_f.imem_addr !== 10'd1 || bus_n.imem_addr !== 10'd1) begin fails++; $display("FAIL reset resume pc: got %0d/%0d want 1", bus_f.imem_addr, bus_n.imem_addr); end
  endtask

  task automatic test_raw_chain;
    int hf, hn;
    logic [31:0] vf, vn;
    prep(ri(6'b001010, 0, 1, 10), ri(6'b001010, 0, 2, 20), rr(6'b000000, 1, 2, 3), HLT, HLT, 0, 32'd0);
    run_to_halt(hf, hn);
    get_reg(3, vf, vn);
    tests++; if (vf !== 32'd30 || vn !== 32'd30) begin fails++; $display("FAIL raw r3: got %0d/%0d want 30", vf, vn); end
    tests++; if (iret_f !== 32'd4 || iret_n !== 32'd4) begin fails++; $display("FAIL raw instret: got %0d/%0d want 4", iret_f, iret_n); end
    tests++; if (hf != 8) begin fails++; $display("FAIL raw halt edge fwd: got %0d want 8", hf); end
    tests++; if (hn != 10) begin fails++; $display("FAIL raw halt edge nofwd: got %0d want 10", hn); end
  endtask

  task automatic test_load_use;
    int hf_dep, hn_dep, hf_ind, hn_ind;
    logic [31:0] vf, vn;
    prep(ri(6'b001000, 0, 5, 32'h40), rr(6'b000000, 4, 4, 6), HLT, HLT, HLT, 32'h40, 32'h55);
    run_to_halt(hf_ind, hn_ind);
    prep(ri(6'b001000, 0, 5, 32'h40), rr(6'b000000, 5, 5, 6), HLT, HLT, HLT, 32'h40, 32'h55);
    run_to_halt(hf_dep, hn_dep);
    get_reg(6, vf, vn);
    tests++; if (vf !== 32'hAA || vn !== 32'hAA) begin fails++; $display("FAIL load_use r6: got %0h/%0h want aa", vf, vn); end
    tests++; if (hf_ind != 7) begin fails++; $display("FAIL load_use independent halt edge: got %0d want 7", hf_ind); end
    tests++; if (hf_dep != 8) begin fails++; $display("FAIL load_use dependent halt edge: got %0d want 8", hf_dep); end
    tests++; if (iret_f !== 32'd3) begin fails++; $display("FAIL load_use instret: got %0d want 3", iret_f); end
  endtask

  task automatic test_branch;
    int hf, hn;
    logic [31:0] f7, n7, f8, n8, f9, n9;
    prep(ri(6'b001110, 0, 0, 2), ri(6'b001010, 0, 7, 1), ri(6'b001010, 0, 8, 1), ri(6'b001010, 0, 9, 3), HLT, 0, 32'd0);
    run_to_halt(hf, hn);
    get_reg(7, f7, n7); get_reg(8, f8, n8); get_reg(9, f9, n9);
    tests++; if (f7 !== 0 || n7 !== 0 || f8 !== 0 || n8 !== 0) begin fails++; $display("FAIL beqz squash: r7 %0d/%0d r8 %0d/%0d want 0", f7, n7, f8, n8); end
    tests++; if (f9 !== 32'd3 || n9 !== 32'd3) begin fails++; $display("FAIL beqz target r9: got %0d/%0d want 3", f9, n9); end
    tests++; if (iret_f !== 32'd3 || iret_n !== 32'd3) begin fails++; $display("FAIL beqz instret: got %0d/%0d want 3", iret_f, iret_n); end
    tests++; if (hf != 9) begin fails++; $display("FAIL beqz halt edge: got %0d want 9", hf); end
    prep(ri(6'b001101, 0, 0, 2), ri(6'b001010, 0, 7, 1), ri(6'b001010, 0, 8, 1), ri(6'b001010, 0, 9, 3), HLT, 0, 32'd0);
    run_to_halt(hf, hn);
    get_reg(7, f7, n7); get_reg(8, f8, n8); get_reg(9, f9, n9);
    tests++; if (f7 !== 1 || n7 !== 1 || f8 !== 1 || n8 !== 1) begin fails++; $display("FAIL bneqz fallthrough: r7 %0d/%0d r8 %0d/%0d want 1", f7, n7, f8, n8); end
    tests++; if (f9 !== 32'd3 || n9 !== 32'd3) begin fails++; $display("FAIL bneqz r9: got %0d/%0d want 3", f9, n9); end
    tests++; if (iret_f !== 32'd5 || iret_n !== 32'd5) begin fails++; $display("FAIL bneqz instret: got %0d/%0d want 5", iret_f, iret_n); end
  endtask

  task automatic test_store_load;
    int hf, hn;
    logic [31:0] vf, vn;
    prep(ri(6'b001010, 0, 1, 32'h77), ri(6'b001001, 0, 1, 5), ri(6'b001000, 0, 2, 5), HLT, HLT, 0, 32'd0);
    run_to_halt(hf, hn);
    get_reg(2, vf, vn);
    tests++; if (we_cnt_f != 1 || we_cnt_n != 1) begin fails++; $display("FAIL store pulses: got %0d/%0d want 1", we_cnt_f, we_cnt_n); end
    tests++; if (we_addr_f != 5 || we_dat_f != 32'h77) begin fails++; $display("FAIL store addr/data: got %0d/%0h want 5/77", we_addr_f, we_dat_f); end
    tests++; if (vf !== 32'h77 || vn !== 32'h77) begin fails++; $display("FAIL store_load r2: got %0h/%0h want 77", vf, vn); end
  endtask

  task automatic test_r0_illegal;
    int hf, hn;
    logic [31:0] vf, vn;
    prep(ri(6'b001010, 0, 0, 5), 32'h5400_0000, HLT, HLT, HLT, 0, 32'd0);
    run_to_halt(hf, hn);
    get_reg(0, vf, vn);
    tests++; if (vf !== 32'd0 || vn !== 32'd0) begin fails++; $display("FAIL r0 write: got %0d/%0d want 0", vf, vn); end
    tests++; if (ill_f !== 1'b1 || ill_n !== 1'b1) begin fails++; $display("FAIL illegal flag: got %b/%b want 1", ill_f, ill_n); end
    tests++; if (halted_f !== 1'b1 || halted_n !== 1'b1) begin fails++; $display("FAIL illegal halted: got %b/%b want 1", halted_f, halted_n); end
    tests++; if (iret_f !== 32'd3 || iret_n !== 32'd3) begin fails++; $display("FAIL illegal instret: got %0d/%0d want 3", iret_f, iret_n); end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_raw_chain();
    test_load_use();
    test_branch();
    test_store_load();
    test_r0_illegal();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached before summary");
    $fatal(1);
  end

endmodule
